mem_rr_arbiter: RTL and testbench

//  Two-port round-robin arbiter/sequencer in front of the single-port memory model.

---
 rtl/mem_rr_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_rr_arbiter
// Two-port round-robin sequencer that issues one request at a time to a
// single-port memory and routes read data back to the requesting port.
// Rev     : 1.0
// ============================================================================
module mem_rr_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wr_en_o,
    output logic              mem_rd_en_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int               CNT_W    = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RWAIT = 2'd2
    } state_t;

    state_t             state_q;
    logic               rr_ptr_q;
    logic               id_q;
    logic               we_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               gnt0_q;
    logic               gnt1_q;
    logic               rvalid0_q;
    logic               rvalid1_q;
    logic [DATA_W-1:0]  rdata0_q;
    logic [DATA_W-1:0]  rdata1_q;
    logic               busy_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic               mem_wr_en_q;
    logic               mem_rd_en_q;
    logic [DATA_W-1:0]  mem_wdata_q;

    logic               win_id;
    logic               win_we;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;

    // Port 1 wins when it is the only requester or when it holds the turn.
    always_comb begin
        win_id    = req1_i & (~req0_i | rr_ptr_q);
        win_we    = win_id ? we1_i    : we0_i;
        win_addr  = win_id ? addr1_i  : addr0_i;
        win_wdata = win_id ? wdata1_i : wdata0_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 1'b0;
            id_q        <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req0_i | req1_i) begin
                        // Grant and memory strobes are launched together so they
                        // are both visible during the ISSUE cycle.
                        state_q     <= ST_ISSUE;
                        busy_q      <= 1'b1;
                        id_q        <= win_id;
                        we_q        <= win_we;
                        gnt0_q      <= ~win_id;
                        gnt1_q      <= win_id;
                        mem_addr_q  <= win_addr;
                        mem_wr_en_q <= win_we;
                        mem_rd_en_q <= ~win_we;
                        mem_wdata_q <= win_we ? win_wdata : '0;
                    end
                end
                ST_ISSUE: begin
                    rr_ptr_q <= ~id_q;
                    if (we_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_RWAIT;
                        cnt_q   <= CNT_INIT;
                    end
                end
                ST_RWAIT: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        if (id_q) begin
                            rdata1_q  <= mem_rdata_i;
                            rvalid1_q <= 1'b1;
                        end else begin
                            rdata0_q  <= mem_rdata_i;
                            rvalid0_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0_o      = gnt0_q;
    assign gnt1_o      = gnt1_q;
    assign rvalid0_o   = rvalid0_q;
    assign rvalid1_o   = rvalid1_q;
    assign rdata0_o    = rdata0_q;
    assign rdata1_o    = rdata1_q;
    assign busy_o      = busy_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wr_en_o = mem_wr_en_q;
    assign mem_rd_en_o = mem_rd_en_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_rr_arbiter
// Directed plus randomized bench for mem_rr_arbiter with a transaction-level
// schedule model and a simple backing memory.
// Rev     : 1.0
// ============================================================================
module tb_mem_rr_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int L  = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, busy_o;
    logic          mem_wr_en_o, mem_rd_en_o;
    logic [DW-1:0] rdata0_o, rdata1_o, mem_wdata_o;
    logic [AW-1:0] mem_addr_o;

    int total = 0;
    int bad   = 0;

    mem_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .rvalid0_o(rvalid0_o), .rvalid1_o(rvalid1_o),
        .rdata0_o(rdata0_o), .rdata1_o(rdata1_o), .busy_o(busy_o),
        .mem_addr_o(mem_addr_o), .mem_wr_en_o(mem_wr_en_o), .mem_rd_en_o(mem_rd_en_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Backing memory with one-cycle read latency.
    logic [DW-1:0] bmem [256];
    always @(posedge clk) begin
        if (mem_rd_en_o) mem_rdata <= bmem[mem_addr_o];
        if (mem_wr_en_o) bmem[mem_addr_o] = mem_wdata_o;
    end

    // Reference model: each accepted request books the bus for a fixed number
    // of cycles and schedules its grant, strobe and read-return events.
    logic [DW-1:0] mmem [256];
    int            en = 0, free_at = 0, rv_at = -1, busy_end = -1;
    bit            ptr = 1'b0, rv_port = 1'b0;
    logic [DW-1:0] rv_data = '0;
    logic          e_gnt0 = 0, e_gnt1 = 0, e_rv0 = 0, e_rv1 = 0, e_wr = 0, e_rd = 0, e_busy = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0, e_rd0 = '0, e_rd1 = '0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            bmem[i] = '0;
            mmem[i] = '0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {e_gnt0, e_gnt1, e_rv0, e_rv1, e_wr, e_rd, e_busy} = '0;
            e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
            ptr = 1'b0; free_at = 0; rv_at = -1; busy_end = -1;
        end else begin
            bit w, wwe;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            en++;
            {e_gnt0, e_gnt1, e_rv0, e_rv1, e_wr, e_rd} = '0;
            if (en == rv_at) begin
                if (rv_port) begin e_rv1 = 1'b1; e_rd1 = rv_data; end
                else         begin e_rv0 = 1'b1; e_rd0 = rv_data; end
            end
            if (en >= free_at && (req0 || req1)) begin
                w   = (req0 && req1) ? ptr : req1;
                wwe = w ? we1 : we0;
                a   = w ? addr1 : addr0;
                d   = w ? wdata1 : wdata0;
                if (w) e_gnt1 = 1'b1; else e_gnt0 = 1'b1;
                e_addr  = a;
                e_wdata = wwe ? d : '0;
                e_wr    = wwe;
                e_rd    = !wwe;
                ptr     = !w;
                if (wwe) begin
                    mmem[a] = d;
                    free_at = en + 2;
                end else begin
                    rv_at   = en + 1 + L;
                    rv_port = w;
                    rv_data = mmem[a];
                    free_at = en + 2 + L;
                end
                busy_end = free_at - 2;
            end
            e_busy = (en <= busy_end);
        end
    end

    int gnt_log[$];
    int rv_cnt = 0;

    always @(negedge clk) begin
        chk("gnt0",   64'(gnt0_o),      64'(e_gnt0));
        chk("gnt1",   64'(gnt1_o),      64'(e_gnt1));
        chk("rvalid0",64'(rvalid0_o),   64'(e_rv0));
        chk("rvalid1",64'(rvalid1_o),   64'(e_rv1));
        chk("rdata0", 64'(rdata0_o),    64'(e_rd0));
        chk("rdata1", 64'(rdata1_o),    64'(e_rd1));
        chk("busy",   64'(busy_o),      64'(e_busy));
        chk("m_addr", 64'(mem_addr_o),  64'(e_addr));
        chk("m_wr",   64'(mem_wr_en_o), 64'(e_wr));
        chk("m_rd",   64'(mem_rd_en_o), 64'(e_rd));
        chk("m_wdata",64'(mem_wdata_o), 64'(e_wdata));
        if (gnt0_o) gnt_log.push_back(0);
        if (gnt1_o) gnt_log.push_back(1);
        if (rvalid0_o || rvalid1_o) rv_cnt++;
    end

    task automatic do_req(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got = 1'b0;
        if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            if ((p == 0) ? gnt0_o : gnt1_o) got = 1'b1;
        end
        chk("req_wait", 64'(got), 64'(1));
        @(posedge clk); #1;
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic rand_port(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            do_req(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0",  64'(gnt0_o),      64'(0));
        chk("rst_busy",  64'(busy_o),      64'(0));
        chk("rst_m_wr",  64'(mem_wr_en_o), 64'(0));
        chk("rst_m_adr", 64'(mem_addr_o),  64'(0));
        chk("rst_rdat1", 64'(rdata1_o),    64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single write
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 32'hDEADBEEF;
        @(posedge clk); @(negedge clk);
        chk("t1_gnt0",  64'(gnt0_o),      64'(1));
        chk("t1_wr_en", 64'(mem_wr_en_o), 64'(1));
        chk("t1_addr",  64'(mem_addr_o),  64'(8'h10));
        chk("t1_wdata", 64'(mem_wdata_o), 64'(32'hDEADBEEF));
        @(posedge clk); #1; req0 = 1'b0;

        // Read-back on port 1
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
        @(posedge clk); @(negedge clk);
        chk("t2_gnt1",  64'(gnt1_o),      64'(1));
        chk("t2_rd_en", 64'(mem_rd_en_o), 64'(1));
        @(posedge clk); #1; req1 = 1'b0;
        @(negedge clk);
        chk("t2_rv_early", 64'(rvalid1_o), 64'(0));
        @(posedge clk); @(negedge clk);
        chk("t2_rvalid", 64'(rvalid1_o), 64'(1));
        chk("t2_rdata",  64'(rdata1_o),  64'(32'hDEADBEEF));
        @(posedge clk); #1;

        // Contention: strict alternation
        gnt_log.delete();
        fork
            begin do_req(0, 1'b1, 8'h01, 32'h11111111); do_req(0, 1'b1, 8'h01, 32'h33333333); end
            begin do_req(1, 1'b1, 8'h02, 32'h22222222); do_req(1, 1'b1, 8'h02, 32'h44444444); end
        join
        @(posedge clk); #1;
        chk("t3_count", 64'(gnt_log.size()), 64'(4));
        if (gnt_log.size() == 4) begin
            chk("t3_ord0", 64'(gnt_log[0]), 64'(0));
            chk("t3_ord1", 64'(gnt_log[1]), 64'(1));
            chk("t3_ord2", 64'(gnt_log[2]), 64'(0));
            chk("t3_ord3", 64'(gnt_log[3]), 64'(1));
        end

        // Same-address write then read
        gnt_log.delete();
        fork
            do_req(0, 1'b1, 8'h20, 32'h5A5A5A5A);
            do_req(1, 1'b0, 8'h20, 32'h0);
        join
        repeat (4) @(posedge clk);
        #1;
        chk("t4_first", 64'(gnt_log.size() > 0 ? gnt_log[0] : 9), 64'(0));
        chk("t4_rdata", 64'(rdata1_o), 64'(32'h5A5A5A5A));

        // Reset during the read wait
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        @(posedge clk); @(negedge clk);
        chk("t5_gnt0", 64'(gnt0_o), 64'(1));
        @(posedge clk); #1; req0 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t5_busy",  64'(busy_o),      64'(0));
        chk("t5_rdat1", 64'(rdata1_o),    64'(0));
        chk("t5_m_adr", 64'(mem_addr_o),  64'(0));
        chk("t5_m_rd",  64'(mem_rd_en_o), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        gnt_log.delete();
        rv_cnt = 0;
        fork
            do_req(0, 1'b1, 8'h30, 32'hA0A0A0A0);
            do_req(1, 1'b1, 8'h31, 32'hB1B1B1B1);
        join
        repeat (4) begin @(posedge clk); #1; end
        chk("t5_first", 64'(gnt_log.size() > 0 ? gnt_log[0] : 9), 64'(0));
        chk("t5_no_rv", 64'(rv_cnt), 64'(0));

        // Idle period
        repeat (20) begin
            @(negedge clk);
            chk("t6_busy", 64'(busy_o),      64'(0));
            chk("t6_wr",   64'(mem_wr_en_o), 64'(0));
            chk("t6_rd",   64'(mem_rd_en_o), 64'(0));
        end
        @(posedge clk); #1;

        // Randomized traffic from both ports
        fork
            rand_port(0, 60);
            rand_port(1, 60);
        join
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
